mc_mips_core: RTL and testbench
===============================

# mc_mips_core

Parametrised multi-cycle successor to the single-cycle 16-bit MIPS datapath. It executes the same 16-bit instruction format through a FETCH/DECODE/EXEC/MEM/WB state machine over a DATA_W-wide datapath. Instruction and data memories are external and reached through req/ack handshakes that tolerate any number of wait states. It is the CPU core instantiated by the system top.

## Interface
- DATA_W, 16: datapath, register, PC and memory-address width; must be at least 16.
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  DATA_W  byte address, equal to PC.
- imem_rdata  in  16  instruction word; valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 means store, 0 means load; valid while dmem_req=1.
- dmem_addr  out  DATA_W  byte address, equal to the ALU result.
- dmem_wdata  out  DATA_W  store data (the rt register).
- dmem_rdata  in  DATA_W  load data; valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- wb_data  out  DATA_W  value written back on the last register write.
- pc  out  DATA_W  current PC.
- halted  out  1  core is in HALT.

## Operation
- Instruction fields: op=IR[15:12], rs=IR[11:10], rt=IR[9:8], rd=IR[7:6], imm=IR[7:0].
- imm is sign-extended to DATA_W.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0111 slt (signed): rd ← rs op rt.
  - 0100 addi: rt ← rs + imm.
  - 0101 lw: rt ← mem[rs + imm].
  - 0110 sw: mem[rs + imm] ← rt.
  - 1000 beq, 1001 bne: branch to PC + 2 + (imm<<1).
  - 1010 j: see Configuration.
  - 1111 halt.
  - Every other opcode is a no-op.
- Register file: 4 × DATA_W. r0 always reads 0 and writes to it are discarded.
- States and transitions:
  - FETCH: hold imem_req=1 until imem_ack, latch IR, then go to DECODE.
  - DECODE: latch A=rs and B=rt, compute PC+2 and the branch target; go to HALT if op=1111, otherwise to EXEC.
  - EXEC: compute ALU result.
    - beq/bne/j/no-op: update PC, go to FETCH.
    - lw/sw: go to MEM.
    - Otherwise: go to WB.
  - MEM: hold dmem_req=1 until dmem_ack.
    - lw: capture dmem_rdata, go to WB.
    - sw: PC ← PC+2, go to FETCH.
  - WB: write rd or rt, wb_data ← value, PC ← PC+2, go to FETCH.
  - HALT: absorbing; only reset leaves it. No requests are issued.
- Arithmetic: modulo 2^DATA_W with no overflow flag. slt produces 1 or 0, zero-extended. PC wraps modulo 2^DATA_W.

## Timing
- Reset values: state=FETCH, PC=0, registers=0, IR=0, wb_data=0, imem_req=0, dmem_req=0, dmem_we=0, halted=0.
- imem_req first rises in the first cycle after reset_n is sampled high.
- Handshake:
  - A transfer completes on a rising edge where req=1 and ack=1. Data is sampled on that edge.
  - req is deasserted in the following cycle.
  - Address and wdata are stable while req=1.
  - ack is ignored while req=0.
- Cycles per instruction with zero wait states (ack high in the request cycle):
  - branch, j, no-op: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
  - Each wait cycle on either port adds 1.
- Reset asserted mid-transaction: req drops on the next edge and any late ack is ignored.
- A register written in WB is visible to the next instruction's DECODE; there is no hazard logic.

## Configuration
- MC_JUMP_EN defined: opcode 1010 sets PC ← {(PC+2)[DATA_W-1:13], IR[11:0], 1'b0} in EXEC, taking 3 cycles.
- MC_JUMP_EN undefined: opcode 1010 is a no-op (PC ← PC+2).

## Structure
- Package mc_mips_pkg holds:
  - opcode localparams;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU-op encoding (and=000, or=001, add=010, sub=110, slt=111);
  - decoded-control struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, beq, bne, jump, alu_op).
- One sub-module: mc_regfile, parametrised by DATA_W, with 2 read ports and 1 write port and r0 hard-wired to zero.

## Test plan
- Reset and memory model: hold reset_n=0 for 3 cycles with DMEM[0]=5 and DMEM[2]=7; program `lw $1,0($0); lw $2,2($0)` → after reset imem_addr=0, all outputs at their reset values; r1=5 and r2=7 after 10 cycles with zero wait states.
- R-type sequence: r1=5, r2=7, then slt $3,$1,$2 followed by sub $1,$1,$2 → wb_data=1, then wb_data=0xFFFE at DATA_W=16 (0xFFFFFFFE at DATA_W=32).
- Branches: bne $3,$0,+2 with r3=1 → next imem_addr = 0x0A from PC=4. beq with r3=1 → next imem_addr = 6. Both take 3 cycles.
- Wait states: ack delayed 3 cycles on every fetch and on the sw → sw occupies 10 cycles; dmem_addr and wdata are stable throughout the wait; DMEM[2]=5 afterwards.
- Halt and reset mid-operation: op 0xF000 → halted=1 and no further req. reset_n pulsed low while dmem_req=1 → req=0 on the next edge and PC=0.
- MC_JUMP_EN: 0xA010 at PC=0 → next fetch at 0x20. Without the macro, the same instruction fetches next from 0x02.

Source files
------------

// File: rtl/mc_mips_pkg.sv
// mc_mips_pkg: opcodes, FSM states, ALU encodings and decoded-control struct for mc_mips_core.
// Control decode is combinational, so it adds no latency of its own.
package mc_mips_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    beq;
        logic    bne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    // Unlisted opcodes (and halt) decode to all-zero control, i.e. a no-op in EXEC.
    function automatic ctrl_t decode(input logic [3:0] op);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (op)
            OP_ADD:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            OP_SUB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
            OP_AND:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_AND; end
            OP_OR:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OR;  end
            OP_SLT:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SLT; end
            OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OP_LW:   begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
            end
            OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:  begin c.beq = 1'b1; c.alu_op = ALU_SUB; end
            OP_BNE:  begin c.bne = 1'b1; c.alu_op = ALU_SUB; end
            OP_J:    c.jump = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 4 x DATA_W register file, two combinational read ports, one synchronous write port.
// r0 always reads zero and ignores writes; a write is visible on the read ports the cycle after.
module mc_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        raddr_a_i,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 2'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 2'd0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 2'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle core for the 16-bit MIPS ISA; 3/4/5 cycles per instruction plus wait states.
// imem/dmem req is held until ack (any number of waits); define MC_JUMP_EN to enable the j opcode.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] pc,
    output logic              halted
);

    state_e            state_q;
    logic [DATA_W-1:0] pc_q, npc_q, btgt_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q, wb_data_q;
    logic              imem_req_q, dmem_req_q, dmem_we_q, halted_q;

    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm_ext, pc_plus2, alu_b, alu_d, jmp_tgt, wb_val;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              alu_zero, br_taken, rf_we;
    logic [1:0]        rf_waddr;

    assign ctrl     = decode(ir_q[15:12]);
    assign imm_ext  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign pc_plus2 = pc_q + DATA_W'(2);

    always_comb begin
        alu_b = ctrl.alu_src ? imm_ext : b_q;
        case (ctrl.alu_op)
            ALU_AND: alu_d = a_q & alu_b;
            ALU_OR:  alu_d = a_q | alu_b;
            ALU_SUB: alu_d = a_q - alu_b;
            ALU_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_d = a_q + alu_b;
        endcase
    end

    assign alu_zero = (alu_d == '0);
    assign br_taken = (ctrl.beq && alu_zero) || (ctrl.bne && !alu_zero);

`ifdef MC_JUMP_EN
    assign jmp_tgt = {npc_q[DATA_W-1:13], ir_q[11:0], 1'b0};
`else
    assign jmp_tgt = npc_q;
`endif

    assign wb_val   = ctrl.mem_to_reg ? mdr_q : alu_q;
    assign rf_we    = (state_q == WB) && ctrl.reg_write;
    assign rf_waddr = ctrl.reg_dst ? ir_q[7:6] : ir_q[9:8];

    mc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .raddr_a_i (ir_q[11:10]),
        .raddr_b_i (ir_q[9:8]),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (wb_val)
    );

    // Every transition into FETCH raises imem_req in the same edge, so a fetch costs one
    // cycle with zero waits; only the first fetch after reset spends an extra idle cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            npc_q      <= '0;
            btgt_q     <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            wb_data_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                DECODE: begin
                    a_q    <= rf_a;
                    b_q    <= rf_b;
                    npc_q  <= pc_plus2;
                    btgt_q <= pc_plus2 + {imm_ext[DATA_W-2:0], 1'b0};
                    if (ir_q[15:12] == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    alu_q <= alu_d;
                    if (ctrl.mem_read || ctrl.mem_write) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= ctrl.mem_write;
                        state_q    <= MEM;
                    end else if (ctrl.reg_write) begin
                        state_q    <= WB;
                    end else begin
                        if (ctrl.jump) begin
                            pc_q <= jmp_tgt;
                        end else if (br_taken) begin
                            pc_q <= btgt_q;
                        end else begin
                            pc_q <= npc_q;
                        end
                        imem_req_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                MEM: begin
                    if (dmem_req_q && dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (ctrl.mem_read) begin
                            mdr_q   <= dmem_rdata;
                            state_q <= WB;
                        end else begin
                            pc_q       <= npc_q;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                WB: begin
                    wb_data_q  <= wb_val;
                    pc_q       <= npc_q;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                HALT: ;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign wb_data    = wb_data_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_mc_mips_core.sv
// tb_mc_mips_core: directed programs against an instruction-level model with req/ack memory responders.
// The j opcode expectation follows MC_JUMP_EN.
`timescale 1ns/1ps
module tb_mc_mips_core;
    localparam int DW = 16;

    logic          clock;
    logic          reset_n;
    logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [DW-1:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, wb_data, pc;
    logic [15:0]   imem_rdata;

    mc_mips_core #(.DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_data(wb_data), .pc(pc), .halted(halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]   imem [64];
    logic [DW-1:0] dmem [64];
    int  fwait, dwait, fcnt, dcnt, cyc, n_hs, last_hs, pend;
    bit  run, noise;
    int  fa [16];
    int  iv [16];

    logic [DW-1:0] m_regs [4];
    logic [DW-1:0] m_dmem [64];
    logic [DW-1:0] m_pc, m_wb, m_daddr, m_dwdata;
    logic          m_dwe, m_halted, m_mem_pend;
    int            halt_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [DW-1:0] a);
        return int'(a[6:1]);
    endfunction

    task automatic wr(input int r, input logic [DW-1:0] v);
        if (r != 0) m_regs[r] = v;
        m_wb = v;
    endtask

    // Executes one instruction architecturally; cost = cycles until the next fetch is
    // acknowledged, excluding that fetch's own wait states.
    task automatic model_step(input logic [15:0] ins, output int cost);
        int op, rs, rt, rd, simm;
        logic [DW-1:0] a, b, imm, npc, v;
        op   = int'(ins[15:12]);
        rs   = int'(ins[11:10]);
        rt   = int'(ins[9:8]);
        rd   = int'(ins[7:6]);
        simm = int'(ins[7:0]);
        if (simm > 127) simm = simm - 256;
        imm  = DW'(simm);
        a    = m_regs[rs];
        b    = m_regs[rt];
        npc  = m_pc + DW'(2);
        cost = 3;
        case (op)
            0: begin wr(rd, a + b); cost = 4; end
            1: begin wr(rd, a - b); cost = 4; end
            2: begin wr(rd, a & b); cost = 4; end
            3: begin wr(rd, a | b); cost = 4; end
            7: begin wr(rd, ($signed(a) < $signed(b)) ? DW'(1) : DW'(0)); cost = 4; end
            4: begin wr(rt, a + imm); cost = 4; end
            5: begin
                v = a + imm;
                m_daddr = v; m_dwe = 1'b0; m_mem_pend = 1'b1;
                wr(rt, m_dmem[widx(v)]);
                cost = 5 + dwait;
            end
            6: begin
                v = a + imm;
                m_daddr = v; m_dwe = 1'b1; m_dwdata = b; m_mem_pend = 1'b1;
                m_dmem[widx(v)] = b;
                cost = 4 + dwait;
            end
            8: if (a == b) npc = npc + DW'(simm * 2);
            9: if (a != b) npc = npc + DW'(simm * 2);
`ifdef MC_JUMP_EN
            10: npc = (npc & ~DW'(16'h1FFF)) | DW'(int'(ins[11:0]) * 2);
`endif
            15: begin m_halted = 1'b1; halt_cyc = cyc + 2; cost = 0; npc = m_pc; end
            default: ;
        endcase
        m_pc = npc;
    endtask

    // Memory responders plus per-cycle comparison against the model.
    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!run) begin
                imem_ack = noise;
                dmem_ack = noise;
            end else begin
                if (imem_req) begin
                    chk("fetch_addr", imem_addr, m_pc);
                    chk("wb_data", wb_data, m_wb);
                    chk("halted_low", halted, 0);
                    chk("dmem_idle_in_fetch", dmem_req, 0);
                end
                if (dmem_req) begin
                    chk("dmem_expected", m_mem_pend, 1);
                    chk("dmem_addr", dmem_addr, m_daddr);
                    chk("dmem_we", dmem_we, m_dwe);
                    if (m_dwe) chk("dmem_wdata", dmem_wdata, m_dwdata);
                end
                if (m_halted && cyc >= halt_cyc) begin
                    chk("halted", halted, 1);
                    chk("halt_no_imem_req", imem_req, 0);
                    chk("halt_no_dmem_req", dmem_req, 0);
                end
                if (imem_req) begin
                    if (fcnt >= fwait) begin
                        imem_ack   = 1'b1;
                        imem_rdata = imem[widx(imem_addr)];
                        fcnt       = 0;
                        if (n_hs > 0) begin
                            if (n_hs < 16) iv[n_hs] = cyc - last_hs;
                            chk("instr_cycles", cyc - last_hs, pend + fwait);
                        end
                        if (n_hs < 16) fa[n_hs] = int'(imem_addr);
                        last_hs = cyc;
                        n_hs++;
                        model_step(imem_rdata, pend);
                    end else begin
                        imem_ack = 1'b0;
                        fcnt++;
                    end
                end else begin
                    imem_ack = noise;
                end
                if (dmem_req) begin
                    if (dcnt >= dwait) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = dmem[widx(dmem_addr)];
                        if (dmem_we) dmem[widx(dmem_addr)] = dmem_wdata;
                        m_mem_pend = 1'b0;
                        dcnt       = 0;
                    end else begin
                        dmem_ack = 1'b0;
                        dcnt++;
                    end
                end else begin
                    dmem_ack = noise;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset(input int fw, input int dw);
        @(posedge clock); #2;
        reset_n = 1'b0;
        run     = 1'b0;
        @(posedge clock); #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clock); @(posedge clock); #2;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        for (int i = 0; i < 64; i++) m_dmem[i] = dmem[i];
        for (int i = 0; i < 16; i++) begin fa[i] = -1; iv[i] = -1; end
        m_pc = '0; m_wb = '0; m_halted = 1'b0; m_mem_pend = 1'b0; m_dwe = 1'b0;
        m_daddr = '0; m_dwdata = '0; halt_cyc = 0;
        fwait = fw; dwait = dw; fcnt = 0; dcnt = 0; n_hs = 0; last_hs = 0; pend = 0;
        reset_n = 1'b1;
        run     = 1'b1;
        @(posedge clock); #2;
        chk("first_imem_req", imem_req, 1);
        chk("first_imem_addr", imem_addr, 0);
    endtask

    task automatic run_until_halt(input int max_cyc);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < max_cyc) begin
            @(posedge clock); #2;
            k++;
        end
        chk("halt_reached", halted, 1);
        repeat (6) @(posedge clock);
        #2;
    endtask

    initial begin
        int k;
        run = 1'b0; noise = 1'b0; reset_n = 1'b0; cyc = 0;

        // Loads then slt: r1=5, r2=7 -> slt writes 1.
        clear_mem();
        imem[0] = 16'h5100; imem[1] = 16'h5202; imem[2] = 16'h76C0;
        dmem[0] = 16'd5; dmem[1] = 16'd7;
        do_reset(0, 0);
        run_until_halt(200);
        chk("slt_wb", wb_data, 16'h0001);
        chk("lw_cycles", iv[1], 5);

        // Same plus sub $1,$1,$2 -> 5-7 wraps.
        imem[3] = 16'h1640;
        do_reset(0, 0);
        run_until_halt(200);
        chk("sub_wb", wb_data, 16'hFFFE);

        // bne taken from PC=4 to 0x0A, then beq not taken at 0x0A.
        clear_mem();
        imem[0] = 16'h4301; imem[1] = 16'hB000; imem[2] = 16'h9C02; imem[5] = 16'h8C05;
        do_reset(0, 0);
        run_until_halt(200);
        chk("bne_target", fa[3], 32'h0A);
        chk("bne_cycles", iv[3], 3);
        chk("beq_fallthru", fa[4], 32'h0C);
        chk("halt_pc", pc, 16'h000C);

        // beq not taken at PC=4 -> 6.
        clear_mem();
        imem[0] = 16'h4301; imem[1] = 16'hB000; imem[2] = 16'h8C02;
        do_reset(0, 0);
        run_until_halt(200);
        chk("beq_next", fa[3], 32'h06);
        chk("beq_cycles", iv[3], 3);

        // Three wait states on every fetch and data access; sw, negative imm, logic ops.
        clear_mem();
        imem[0] = 16'h4105; imem[1] = 16'h6102; imem[2] = 16'h42FD;
        imem[3] = 16'h26C0; imem[4] = 16'h36C0; imem[5] = 16'h06C0;
        do_reset(3, 3);
        run_until_halt(400);
        chk("sw_cycles", iv[2], 10);
        chk("sw_stored", dmem[1], 16'h0005);
        chk("add_wrap_wb", wb_data, 16'h0002);

        // Reset while a load is waiting; late/spurious acks must be ignored afterwards.
        clear_mem();
        imem[0] = 16'h5100; dmem[0] = 16'd5;
        do_reset(0, 30);
        k = 0;
        while (dmem_req !== 1'b1 && k < 50) begin
            @(posedge clock); #2;
            k++;
        end
        chk("dmem_req_seen", dmem_req, 1);
        noise = 1'b1;
        do_reset(0, 0);
        run_until_halt(200);
        chk("post_reset_lw_wb", wb_data, 16'h0005);
        noise = 1'b0;

        // j 0x010: target depends on whether the jump feature is built in.
        clear_mem();
        imem[0] = 16'hA010;
        do_reset(0, 0);
        run_until_halt(200);
`ifdef MC_JUMP_EN
        chk("jump_next_fetch", fa[1], 32'h20);
`else
        chk("jump_next_fetch", fa[1], 32'h02);
`endif
        chk("jump_cycles", iv[1], 3);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
